ser_to_par_clr: RTL and testbench
=================================

Name: ser_to_par_clr

Overview:
- Bit-serial to word-parallel assembler.
- Sits directly downstream of the DFF_Clr retiming flop and consumes its Q output as the serial data stream.
- Collects WIDTH bits per frame, MSB first, into a parallel word.
- Presents each completed word on a valid/ready handshake to the parallel datapath.
- Reports overrun when a word is dropped.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  single rising-edge clock.
- _Rst  input  1  asynchronous active-low reset.
- _Clr  input  1  synchronous active-low clear; same effect as reset, applied on the clock edge.
- Din  input  1  serial data from the upstream DFF_Clr Q output.
- En  input  1  bit-enable; Din and Frm are sampled only on edges where En=1.
- Frm  input  1  frame-start strobe; high together with the first (MSB) bit of a frame.
- Ready  input  1  downstream accepts Dout this cycle.
- Dout  output  WIDTH  assembled word, registered.
- Valid  output  1  Dout holds an unconsumed word.
- Busy  output  1  a frame is in progress.
- Ovr  output  1  sticky overrun flag.
- PErr  output  1  parity error, sticky; driven only when PARITY_CHECK_EN is defined.

Behaviour:
- Reset (_Rst=0, asynchronous) and clear (_Clr=0 at an edge):
  - State=IDLE, shift register=0, counter=0.
  - Dout=0, Valid=0, Busy=0, Ovr=0, PErr=0.
  - _Clr has priority over every other input at that edge.
- States: IDLE, SHIFT, and PAR (PAR exists only with PARITY_CHECK_EN).
- IDLE:
  - On En&Frm: load shreg[0]=Din, cnt=1, go to SHIFT, Busy=1 from the next cycle.
  - All other inputs are ignored.
- SHIFT:
  - On En: shreg={shreg[WIDTH-2:0],Din}, cnt=cnt+1.
  - En=0: state, counter and shift register hold.
  - Frm=1 during SHIFT (with En): resynchronise. The current partial frame is discarded and Din is taken as the new MSB with cnt=1. No Ovr is raised.
  - When the WIDTH-th bit is sampled, the frame completes:
    - without parity: go to IDLE;
    - with parity: go to PAR.
- Word transfer:
  - On completion, the full word is written to Dout and Valid=1 on the next edge.
  - Latency: Valid rises 1 cycle after the edge that samples the last data bit.
  - Without parity, a new frame may start on the very next En&Frm. Back-to-back frames are legal.
- Handshake:
  - Transfer occurs on any edge with Valid&Ready.
  - Valid falls after the transfer unless a new word completes on the same edge. In that case Dout is replaced and Valid stays 1.
  - Dout is stable while Valid=1 and Ready=0.
- Overrun:
  - A word that completes while Valid=1 and Ready=0 is dropped.
  - Dout keeps the old word and Ovr is set.
  - Ovr clears only on reset or _Clr.
- Busy=1 in SHIFT and PAR, 0 in IDLE.
- Counter never exceeds WIDTH; it wraps to 0 on frame completion.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - One extra even-parity bit follows each frame's LSB, sampled in PAR on En.
  - Parity is computed over the word plus the parity bit.
  - Odd result sets PErr (sticky); the word is still delivered.
  - Delivery (Valid) occurs 1 cycle after the parity bit is sampled.
  - Frm in PAR is treated as resync and the pending word is discarded.
- Undefined:
  - No PAR state and no PErr port; the frame is WIDTH bits only.

Decomposition:
- Shared package / defines header:
  - state encodings ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_PAR=2'b10;
  - default WIDTH;
  - the parity polarity constant PAR_EVEN=1.
- Sub-module ser_bit_counter:
  - CNT_W-bit counter with load-1, increment, hold and clear;
  - done output when count==WIDTH-1 and En;
  - instanced once.
- Everything else is in the top module.

Test Plan:
- Reset/clear values:
  - hold _Rst=0 mid-frame (after 3 of 8 bits), release;
  - then separately pulse _Clr=0 while Valid=1.
  - Each time: Dout=0, Valid=0, Busy=0, Ovr=0, and the partial frame is lost.
- Single frame:
  - WIDTH=8, En=1 every cycle, Frm with first bit, bits 1,0,1,1,0,0,1,0, Ready=1.
  - Dout=8'hB2 and Valid=1 for exactly 1 cycle, 1 cycle after the last bit.
- Gapped enable:
  - same frame with En toggling 1,0,1,0.
  - Dout=8'hB2 and Busy holds across gaps.
- Back-to-back with stall:
  - frames 8'h5A then 8'hC3, Ready=0 throughout.
  - Dout stays 8'h5A, Ovr=1 after the second frame completes.
  - Raising Ready then gives one transfer and Valid=0.
- Resync:
  - Frm re-asserted after 4 bits, followed by 8'h0F.
  - Exactly one word 8'h0F is delivered, Ovr=0.
- PARITY_CHECK_EN:
  - 8'hB2 with parity bit 0 gives PErr=0 and Valid 1 cycle after the parity bit.
  - 8'hB2 with parity bit 1 gives PErr=1 and Dout=8'hB2.

Source files
------------

// File: rtl/ser_to_par_clr_pkg.sv
// ser_to_par_clr_pkg: shared types and constants for the bit-serial to
// word-parallel assembler.
//   state_t        FSM state encoding (ST_PAR only with PARITY_CHECK_EN)
//   DEFAULT_WIDTH  default data bits per frame
//   DEFAULT_CNT_W  default bit-counter width
//   PAR_EVEN       parity polarity (1 = even parity expected)
//   parity_err()   parity check over a word plus its parity bit
// Optional feature macro: PARITY_CHECK_EN
package ser_to_par_clr_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = 5;
    localparam logic        PAR_EVEN      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
`ifdef PARITY_CHECK_EN
        ,
        ST_PAR   = 2'b10
`endif
    } state_t;

    // Word is zero-extended by the caller; extra zeros do not change parity.
    function automatic logic parity_err(input logic [31:0] word, input logic pbit);
        return (^word) ^ pbit ^ ~PAR_EVEN;
    endfunction

endpackage

// File: rtl/ser_to_par_clr_if.sv
// ser_to_par_clr_if: serial input stream and parallel output handshake of
// the assembler.
//   Din, En, Frm   serial bit, bit-enable, frame-start strobe
//   Ready          downstream accepts Dout
//   Dout, Valid    assembled word and its valid flag
//   Busy, Ovr      frame in progress, sticky overrun
//   PErr           sticky parity error (only with PARITY_CHECK_EN)
// Modports: master (stream source / word sink), slave (the assembler).
// Optional feature macro: PARITY_CHECK_EN
interface ser_to_par_clr_if
    import ser_to_par_clr_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             Din;
    logic             En;
    logic             Frm;
    logic             Ready;
    logic [WIDTH-1:0] Dout;
    logic             Valid;
    logic             Busy;
    logic             Ovr;
`ifdef PARITY_CHECK_EN
    logic             PErr;

    modport master (
        output Din, En, Frm, Ready,
        input  Dout, Valid, Busy, Ovr, PErr
    );

    modport slave (
        input  Din, En, Frm, Ready,
        output Dout, Valid, Busy, Ovr, PErr
    );
`else
    modport master (
        output Din, En, Frm, Ready,
        input  Dout, Valid, Busy, Ovr
    );

    modport slave (
        input  Din, En, Frm, Ready,
        output Dout, Valid, Busy, Ovr
    );
`endif

endinterface

// File: rtl/ser_to_par_clr_bit_counter.sv
// ser_bit_counter: bit position counter for the assembler.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (highest priority after reset)
//   load        restart at 1 (first bit of a frame sampled)
//   inc         count one more bit
//   done        the bit sampled this edge is the last of the frame
// The count wraps to 0 on completion, so it never exceeds WIDTH-1 here.
module ser_bit_counter
    import ser_to_par_clr_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;

    assign done = inc && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (done) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ser_to_par_clr.sv
// ser_to_par_clr: bit-serial to word-parallel assembler. Collects WIDTH
// bits per frame, MSB first, from the upstream retiming flop and offers
// each word on a valid/ready handshake.
//   Clk   rising-edge clock
//   _Rst  asynchronous active-low reset
//   _Clr  synchronous active-low clear (wins over all other inputs)
//   bus   ser_to_par_clr_if.slave: Din/En/Frm in, Ready in,
//         Dout/Valid/Busy/Ovr (and PErr) out
// Parameters: WIDTH (2..32), CNT_W (2**CNT_W > WIDTH).
// Optional feature macro: PARITY_CHECK_EN (even parity bit after the LSB).
module ser_to_par_clr
    import ser_to_par_clr_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic            Clk,
    input  logic            _Rst,
    input  logic            _Clr,
    ser_to_par_clr_if.slave bus
);

    // Without parity the last bit is taken straight from Din, so the shift
    // register only needs to hold the first WIDTH-1 bits.
`ifdef PARITY_CHECK_EN
    localparam int unsigned SR_W = WIDTH;
`else
    localparam int unsigned SR_W = WIDTH - 1;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [SR_W-1:0]  shreg;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] word;
    logic             valid_q;
    logic             ovr_q;
    logic             start;
    logic             inc;
    logic             done;
    logic             deliver;
    logic             busy;
`ifdef PARITY_CHECK_EN
    logic             perr_q;
    logic             par_sample;
`endif

    ser_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (Clk),
        .rst_n (_Rst),
        .clr   (!_Clr),
        .load  (start),
        .inc   (inc),
        .done  (done)
    );

    // State register
    always_ff @(posedge Clk or negedge _Rst) begin
        if (!_Rst) begin
            state <= ST_IDLE;
        end else if (!_Clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a sampled Frm restarts the frame from any state.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_SHIFT;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (done) begin
`ifdef PARITY_CHECK_EN
                        state_nxt = ST_PAR;
`else
                        state_nxt = ST_IDLE;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PAR: begin
                    if (bus.En) begin
                        state_nxt = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        start   = bus.En && bus.Frm;
        inc     = bus.En && !bus.Frm && (state == ST_SHIFT);
        busy    = (state != ST_IDLE);
`ifdef PARITY_CHECK_EN
        par_sample = bus.En && !bus.Frm && (state == ST_PAR);
        deliver    = par_sample;
        word       = shreg;
`else
        deliver    = done;
        word       = {shreg, bus.Din};
`endif
    end

    // Datapath: shift register, output word, handshake and sticky flags
    always_ff @(posedge Clk or negedge _Rst) begin
        if (!_Rst) begin
            shreg   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else if (!_Clr) begin
            shreg   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            if (start) begin
                shreg <= SR_W'(bus.Din);
            end else if (inc) begin
                shreg <= SR_W'({shreg, bus.Din});
            end

            // A completing word replaces Dout only if the slot is free or
            // being consumed this edge; otherwise it is dropped.
            if (deliver) begin
                if (valid_q && !bus.Ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    dout_q  <= word;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && bus.Ready) begin
                valid_q <= 1'b0;
            end

`ifdef PARITY_CHECK_EN
            if (par_sample && parity_err(32'(shreg), bus.Din)) begin
                perr_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.Dout  = dout_q;
    assign bus.Valid = valid_q;
    assign bus.Busy  = busy;
    assign bus.Ovr   = ovr_q;
`ifdef PARITY_CHECK_EN
    assign bus.PErr  = perr_q;
`endif

endmodule

// File: tb/tb_ser_to_par_clr.sv
// tb_ser_to_par_clr: directed self-checking bench for ser_to_par_clr
// (WIDTH=8). Honours PARITY_CHECK_EN by appending an even parity bit.
module tb_ser_to_par_clr;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ser_to_par_clr_if #(.WIDTH(8)) bus ();

    ser_to_par_clr #(
        .WIDTH (8),
        .CNT_W (5)
    ) dut (
        .Clk  (clk),
        ._Rst (rst_n),
        ._Clr (clr_n),
        .bus  (bus)
    );

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic drive(input logic d, input logic en, input logic frm);
        bus.Din = d;
        bus.En  = en;
        bus.Frm = frm;
        @(posedge clk);
        #1;
    endtask

    // Bits 7..1 of a frame, Frm with the MSB, optional idle gap after each.
    task automatic send_head(input logic [7:0] w, input bit gap);
        for (int i = 7; i >= 1; i--) begin
            drive(w[i], 1'b1, (i == 7));
            if (gap) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    // LSB (and parity bit); rdy_last raises Ready for the completing edge.
    task automatic send_tail(input logic [7:0] w, input bit rdy_last);
`ifdef PARITY_CHECK_EN
        drive(w[0], 1'b1, 1'b0);
        if (rdy_last) bus.Ready = 1'b1;
        drive(^w, 1'b1, 1'b0);
`else
        if (rdy_last) bus.Ready = 1'b1;
        drive(w[0], 1'b1, 1'b0);
`endif
    endtask

    task automatic test_reset;
        logic [4:0] rest;
        rst_n = 1'b0;
        clr_n = 1'b1;
        bus.Ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        checks++; if (bus.Dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want %h", bus.Dout, 8'h00); end
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.Valid); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        checks++; if (bus.Ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.Ovr); end
        // three bits of 8'hB2 then asynchronous reset mid-frame
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", bus.Busy); end
        bus.En = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", bus.Busy); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.Ready = 1'b1;
        rest = 5'b10010;
        for (int i = 4; i >= 0; i--) drive(rest[i], 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL reset_lost_valid: got %b want 0", bus.Valid); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_lost_busy: got %b want 0", bus.Busy); end
        checks++; if (bus.Dout !== 8'h00) begin errors++; $display("FAIL reset_lost_dout: got %h want %h", bus.Dout, 8'h00); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single;
        bus.Ready = 1'b1;
        send_head(8'hB2, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", bus.Valid); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.Busy); end
        send_tail(8'hB2, 1'b0);
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.Valid); end
        checks++; if (bus.Dout !== 8'hB2) begin errors++; $display("FAIL single_dout: got %h want %h", bus.Dout, 8'hB2); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", bus.Busy); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", bus.Valid); end
        checks++; if (bus.Dout !== 8'hB2) begin errors++; $display("FAIL single_dout_hold: got %h want %h", bus.Dout, 8'hB2); end
    endtask

    task automatic test_resync;
        logic [3:0] junk;
        bus.Ready = 1'b1;
        junk = 4'b1111;
        for (int i = 3; i >= 0; i--) drive(junk[i], 1'b1, (i == 3));
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL resync_partial_valid: got %b want 0", bus.Valid); end
        send_head(8'h0F, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL resync_early_valid: got %b want 0", bus.Valid); end
        send_tail(8'h0F, 1'b0);
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b want 1", bus.Valid); end
        checks++; if (bus.Dout !== 8'h0F) begin errors++; $display("FAIL resync_dout: got %h want %h", bus.Dout, 8'h0F); end
        checks++; if (bus.Ovr !== 1'b0) begin errors++; $display("FAIL resync_ovr: got %b want 0", bus.Ovr); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL resync_one_word: got %b want 0", bus.Valid); end
    endtask

    task automatic test_gapped;
        logic [7:0] w;
        w = 8'hB2;
        bus.Ready = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            drive(w[i], 1'b1, (i == 7));
            drive(1'b0, 1'b0, 1'b0);
            checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL gapped_busy_bit%0d: got %b want 1", i, bus.Busy); end
        end
        send_tail(w, 1'b0);
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL gapped_valid: got %b want 1", bus.Valid); end
        checks++; if (bus.Dout !== 8'hB2) begin errors++; $display("FAIL gapped_dout: got %h want %h", bus.Dout, 8'hB2); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        bus.Ready = 1'b0;
        send_head(8'h5A, 1'b0);
        send_tail(8'h5A, 1'b0);
        checks++; if (bus.Dout !== 8'h5A) begin errors++; $display("FAIL b2b_first_dout: got %h want %h", bus.Dout, 8'h5A); end
        checks++; if (bus.Ovr !== 1'b0) begin errors++; $display("FAIL b2b_first_ovr: got %b want 0", bus.Ovr); end
        send_head(8'hC3, 1'b0);
        checks++; if (bus.Dout !== 8'h5A) begin errors++; $display("FAIL b2b_stall_dout: got %h want %h", bus.Dout, 8'h5A); end
        send_tail(8'hC3, 1'b0);
        checks++; if (bus.Dout !== 8'h5A) begin errors++; $display("FAIL b2b_drop_dout: got %h want %h", bus.Dout, 8'h5A); end
        checks++; if (bus.Ovr !== 1'b1) begin errors++; $display("FAIL b2b_ovr: got %b want 1", bus.Ovr); end
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", bus.Valid); end
        bus.Ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL b2b_transfer_valid: got %b want 0", bus.Valid); end
        checks++; if (bus.Ovr !== 1'b1) begin errors++; $display("FAIL b2b_ovr_sticky: got %b want 1", bus.Ovr); end
    endtask

    task automatic test_clear;
        logic [5:0] rest;
        bus.Ready = 1'b0;
        send_head(8'hE7, 1'b0);
        send_tail(8'hE7, 1'b0);
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL clear_pre_valid: got %b want 1", bus.Valid); end
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        clr_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        clr_n = 1'b1;
        checks++; if (bus.Dout !== 8'h00) begin errors++; $display("FAIL clear_dout: got %h want %h", bus.Dout, 8'h00); end
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b want 0", bus.Valid); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", bus.Busy); end
        checks++; if (bus.Ovr !== 1'b0) begin errors++; $display("FAIL clear_ovr: got %b want 0", bus.Ovr); end
        rest = 6'b100111;
        for (int i = 5; i >= 0; i--) drive(rest[i], 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL clear_lost_valid: got %b want 0", bus.Valid); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_handoff;
        bus.Ready = 1'b0;
        send_head(8'hA1, 1'b0);
        send_tail(8'hA1, 1'b0);
        send_head(8'h3C, 1'b0);
        send_tail(8'h3C, 1'b1);
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL handoff_valid: got %b want 1", bus.Valid); end
        checks++; if (bus.Dout !== 8'h3C) begin errors++; $display("FAIL handoff_dout: got %h want %h", bus.Dout, 8'h3C); end
        checks++; if (bus.Ovr !== 1'b0) begin errors++; $display("FAIL handoff_ovr: got %b want 0", bus.Ovr); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL handoff_drain: got %b want 0", bus.Valid); end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity;
        bus.Ready = 1'b1;
        send_head(8'hB2, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL par_wait_valid: got %b want 0", bus.Valid); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL par_wait_busy: got %b want 1", bus.Busy); end
        drive(1'b0, 1'b1, 1'b0);
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL par_good_valid: got %b want 1", bus.Valid); end
        checks++; if (bus.Dout !== 8'hB2) begin errors++; $display("FAIL par_good_dout: got %h want %h", bus.Dout, 8'hB2); end
        checks++; if (bus.PErr !== 1'b0) begin errors++; $display("FAIL par_good_perr: got %b want 0", bus.PErr); end
        drive(1'b0, 1'b0, 1'b0);
        send_head(8'hB2, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (bus.PErr !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b want 1", bus.PErr); end
        checks++; if (bus.Dout !== 8'hB2) begin errors++; $display("FAIL par_bad_dout: got %h want %h", bus.Dout, 8'hB2); end
        checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL par_bad_valid: got %b want 1", bus.Valid); end
        drive(1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        clr_n     = 1'b1;
        bus.Din   = 1'b0;
        bus.En    = 1'b0;
        bus.Frm   = 1'b0;
        bus.Ready = 1'b0;
        test_reset();
        test_single();
        test_resync();
        test_gapped();
        test_back_to_back();
        test_clear();
        test_handoff();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
